// File: rtl/data_mem_responder.sv
// Responder end of the CPU data-memory port: one outstanding load/store, LATENCY wait cycles,
// then a response held until accepted. Byte-enabled word RAM with misaligned/out-of-range flagging.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       req_fire;
    logic       issue;
    logic       rsp_done;

    logic             we_p0;
    logic [31:0]      addr_p0;
    logic [31:0]      wdata_p0;
    logic [3:0]       be_p0;
    logic             acc_err_p0;
    logic [IDX_W-1:0] idx_p0;

    logic [31:0] mem [DEPTH_WORDS];

    // Upper address bits are checked rather than dropped, so aliasing into the RAM is impossible.
    assign acc_err_p0 = (addr_p0[1:0] != 2'b00) || ({2'b00, addr_p0[31:2]} >= DEPTH_LIM);
    assign idx_p0     = addr_p0[2 +: IDX_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // RESP spends its first cycle performing the access; rsp_valid rises on the edge closing it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_ready = 1'b0;
        req_fire  = 1'b0;
        issue     = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    req_fire  = 1'b1;
                    state_nxt = (LATENCY > 0) ? WAIT : RESP;
                    cnt_nxt   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                if (!rsp_valid) begin
                    issue = 1'b1;
                end else if (rsp_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Accepted request
    always_ff @(posedge clk) begin
        if (req_fire) begin
            we_p0    <= req_we;
            addr_p0  <= req_addr;
            wdata_p0 <= req_wdata;
            be_p0    <= req_be;
        end
    end

    // Access / response
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (issue) begin
            rsp_valid <= 1'b1;
            rsp_err   <= acc_err_p0;
            rsp_rdata <= (!we_p0 && !acc_err_p0) ? mem[idx_p0] : 32'd0;
        end else if (rsp_done) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end
    end

    // A reset on the commit edge drops the store.
    always_ff @(posedge clk) begin
        if (!rst && issue && we_p0 && !acc_err_p0) begin
            for (int b = 0; b < 4; b++) begin
                if (be_p0[b]) begin
                    mem[idx_p0][8*b +: 8] <= wdata_p0[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=2 and a LATENCY=0 instance, each driven with directed
// and random load/store traffic and compared every cycle against a transaction-timing model.
module tb_data_mem_responder;
    localparam int DEPTH = 256;

    logic clk;
    int   n_vec;
    int   n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int ln, input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL lane%0d %s: got %h, expected %h", ln, nm, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = (g == 0) ? 2 : 0;

        logic        rst, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
        logic [31:0] req_addr, req_wdata, rsp_rdata;
        logic [3:0]  req_be;
        bit          done;

        bit          m_busy, m_valid, m_err, t_we;
        int          m_age, cyc;
        logic [31:0] m_rdata, t_addr, t_wdata;
        logic [3:0]  t_be;
        logic [31:0] m_ram [DEPTH];

        data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
            .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
            .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
            .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
        );

        // Model: a transaction is accepted when idle, its response appears LAT+1 edges later
        // and lives until the requester takes it.
        initial begin
            bit e;
            int w;
            m_busy = 0; m_valid = 0; m_err = 0; m_rdata = 0; m_age = 0; cyc = 0;
            forever begin
                @(posedge clk);
                cyc++;
                if (rst) begin
                    m_busy = 0; m_valid = 0; m_err = 0; m_rdata = 0;
                end else if (m_valid) begin
                    if (rsp_ready) begin
                        m_busy = 0; m_valid = 0; m_err = 0; m_rdata = 0;
                    end
                end else if (m_busy) begin
                    m_age++;
                    if (m_age == LAT + 1) begin
                        e = (t_addr % 4 != 0) || (t_addr / 4 >= DEPTH);
                        m_valid = 1; m_err = e; m_rdata = 0;
                        if (!e) begin
                            w = int'(t_addr / 4);
                            if (t_we) begin
                                for (int b = 0; b < 4; b++)
                                    if (t_be[b]) m_ram[w][8*b +: 8] = t_wdata[8*b +: 8];
                            end else begin
                                m_rdata = m_ram[w];
                            end
                        end
                    end
                end else if (req_valid) begin
                    m_busy = 1; m_age = 0;
                    t_we = req_we; t_addr = req_addr; t_wdata = req_wdata; t_be = req_be;
                end
            end
        end

        initial begin
            forever begin
                @(negedge clk);
                n_vec++;
                if (req_ready !== !m_busy || rsp_valid !== m_valid ||
                    rsp_rdata !== m_rdata || rsp_err !== m_err) begin
                    n_bad++;
                    $display("FAIL lane%0d cycle_cmp @%0d: got rdy=%b vld=%b rdata=%h err=%b, expected rdy=%b vld=%b rdata=%h err=%b",
                             g, cyc, req_ready, rsp_valid, rsp_rdata, rsp_err, !m_busy, m_valid, m_rdata, m_err);
                end
            end
        end

        // Called at a negedge; returns at the negedge after the response handshake.
        task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] b, input int hold, input bit rnd,
                            output logic [31:0] rd, output logic er, output int lat, output int acc);
            int n;
            rd = 0; er = 0; lat = 0; acc = 0;
            req_valid = 1; req_we = we; req_addr = a; req_wdata = wd; req_be = b; rsp_ready = 0;
            n = 0;
            while (!req_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (!req_ready) begin
                chk(g, "accept_timeout", 32'(req_ready), 32'd1);
                req_valid = 0;
                return;
            end
            @(posedge clk);
            @(negedge clk);
            acc = cyc;
            req_valid = 0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
            while (!rsp_valid && lat < 200) begin
                @(negedge clk);
                lat++;
            end
            if (!rsp_valid) begin
                chk(g, "rsp_timeout", 32'(rsp_valid), 32'd1);
                return;
            end
            rd = rsp_rdata;
            er = rsp_err;
            for (int h = 0; h < hold; h++) begin
                rsp_ready = 0;
                @(negedge clk);
                chk(g, "hold_rdata", rsp_rdata, rd);
                chk(g, "hold_vld_rdy_err", {29'd0, rsp_valid, req_ready, rsp_err}, {29'd0, 1'b1, 1'b0, er});
            end
            n = 0;
            rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            while (!rsp_ready && n < 50) begin
                @(negedge clk);
                n++;
                rsp_ready = (n < 50) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            rsp_ready = 1'($urandom_range(0, 1));
        endtask

        initial begin
            logic [31:0] rd, ad;
            logic        er;
            int          lat, a1, a2, r;
            rst = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_be = 0;
            rsp_ready = 0; done = 0;
            repeat (3) @(negedge clk);
            rst = 0;
            chk(g, "reset_ready", 32'(req_ready), 32'd1);
            chk(g, "reset_valid", 32'(rsp_valid), 32'd0);
            chk(g, "reset_rdata", rsp_rdata, 32'd0);
            chk(g, "reset_err", 32'(rsp_err), 32'd0);

            xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, rd, er, lat, a1);
            chk(g, "st_latency", lat, LAT + 1);
            chk(g, "st_err", 32'(er), 32'd0);
            chk(g, "st_rdata", rd, 32'd0);
            xact(1'b0, 32'h10, 32'h0, 4'h0, 0, 0, rd, er, lat, a1);
            chk(g, "ld_latency", lat, LAT + 1);
            chk(g, "ld_rdata", rd, 32'hDEADBEEF);
            xact(1'b1, 32'h10, 32'h000000AA, 4'h1, 0, 0, rd, er, lat, a1);
            xact(1'b0, 32'h10, 32'h0, 4'h0, 0, 0, rd, er, lat, a1);
            chk(g, "byte_merge", rd, 32'hDEADBEAA);
            xact(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 0, 0, rd, er, lat, a1);
            chk(g, "be0_err", 32'(er), 32'd0);
            xact(1'b0, 32'h12, 32'h0, 4'h0, 0, 0, rd, er, lat, a1);
            chk(g, "misalign_ld", {rd[30:0], er}, 32'd1);
            xact(1'b0, 32'h400, 32'h0, 4'h0, 0, 0, rd, er, lat, a1);
            chk(g, "range_ld", {rd[30:0], er}, 32'd1);
            xact(1'b1, 32'h12, 32'h11111111, 4'hF, 0, 0, rd, er, lat, a1);
            chk(g, "misalign_st_err", 32'(er), 32'd1);
            xact(1'b1, 32'h410, 32'h22222222, 4'hF, 0, 0, rd, er, lat, a1);
            chk(g, "range_st_err", 32'(er), 32'd1);
            xact(1'b0, 32'h10, 32'h0, 4'h0, 5, 0, rd, er, lat, a1);
            chk(g, "no_alias_rdata", rd, 32'hDEADBEAA);

            for (int i = 0; i < DEPTH; i++)
                xact(1'b1, 32'(i * 4), $urandom, 4'hF, 0, 1, rd, er, lat, a1);

            xact(1'b1, 32'h20, 32'h12345678, 4'hF, 0, 0, rd, er, lat, a1);
            req_valid = 1; req_we = 1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
            @(posedge clk);
            @(negedge clk);
            req_valid = 0;
            rst = 1;
            @(posedge clk);
            @(negedge clk);
            rst = 0;
            chk(g, "rst_wait_ready", 32'(req_ready), 32'd1);
            chk(g, "rst_wait_valid", 32'(rsp_valid), 32'd0);
            xact(1'b0, 32'h20, 32'h0, 4'h0, 0, 0, rd, er, lat, a1);
            chk(g, "dropped_store", rd, 32'h12345678);

            xact(1'b0, 32'h20, 32'h0, 4'h0, 0, 0, rd, er, lat, a1);
            xact(1'b0, 32'h20, 32'h0, 4'h0, 0, 0, rd, er, lat, a2);
            chk(g, "b2b_spacing", a2 - a1, LAT + 3);
            chk(g, "b2b_latency", lat, LAT + 1);

            for (int i = 0; i < 300; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                r = int'($urandom_range(0, 9));
                ad = 32'($urandom_range(0, DEPTH - 1)) * 4;
                if (r == 8) ad = ad + 32'($urandom_range(1, 3));
                if (r == 9) ad = ($urandom & 32'hFFFF_FFFC) | (32'h1 << $urandom_range(10, 31));
                xact(1'($urandom), ad, $urandom, 4'($urandom), int'($urandom_range(0, 1)), 1,
                     rd, er, lat, a1);
            end
            done = 1;
        end
    end

    initial begin
        int c;
        n_vec = 0;
        n_bad = 0;
        c = 0;
        while (!(lane[0].done && lane[1].done) && c < 60000) begin
            @(posedge clk);
            c++;
        end
        if (!(lane[0].done && lane[1].done)) begin
            n_vec++;
            n_bad++;
            $display("FAIL run_timeout: lanes done %b%b after %0d cycles, expected 11", lane[0].done, lane[1].done, c);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
